// File: rtl/read_empty_ctrl_if.sv
// Read-side FIFO pointer bundle: request and write pointer in, address/pointer/flags out.
// The master modport is the read-domain consumer; the slave modport is read_empty_ctrl.
interface read_empty_ctrl_if #(
    parameter int ADDR_SIZE = 4
);
    logic                 read_inc;
    logic [ADDR_SIZE:0]   write_ptr;
    logic [ADDR_SIZE-1:0] read_addr;
    logic [ADDR_SIZE:0]   read_ptr;
    logic                 empty;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   read_level;
    logic                 underflow;

    modport master (
        output read_inc,
        output write_ptr,
        input  read_addr,
        input  read_ptr,
        input  empty,
        input  almost_empty,
        input  read_level,
        input  underflow
    );

    modport slave (
        input  read_inc,
        input  write_ptr,
        output read_addr,
        output read_ptr,
        output empty,
        output almost_empty,
        output read_level,
        output underflow
    );
endinterface

// File: rtl/read_empty_ctrl.sv
// Read-domain pointer and empty/level controller of the async FIFO: synchronizes the
// Gray write pointer, advances the binary/Gray read pointer and registers every flag.
module read_empty_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int AE_LEVEL  = 2
) (
    input  logic               read_clk,
    input  logic               read_reset,
    read_empty_ctrl_if.slave   bus
);
    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0] wsync1;
    logic [PW-1:0] wsync2;
    logic [PW-1:0] bin;
    logic [PW-1:0] gray;
    logic          empty_q;
    logic          almost_empty_q;
    logic [PW-1:0] level_q;
    logic          underflow_q;

    logic          read_ok;
    logic [PW-1:0] next_bin;
    logic [PW-1:0] next_gray;
    logic [PW-1:0] wbin;
    logic [PW-1:0] next_level;
    logic          next_empty;
    logic          next_almost_empty;

    // Two-flop synchronizer; write_ptr moves one bit per write edge, so any sample is valid.
    always_ff @(posedge read_clk or negedge read_reset) begin
        if (!read_reset) begin
            wsync1 <= '0;
            wsync2 <= '0;
        end else begin
            wsync1 <= bus.write_ptr;
            wsync2 <= wsync1;
        end
    end

    always_comb begin
        read_ok   = bus.read_inc & ~empty_q;
        next_bin  = bin + {{(PW-1){1'b0}}, read_ok};
        next_gray = (next_bin >> 1) ^ next_bin;

        wbin         = '0;
        wbin[PW-1]   = wsync2[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ wsync2[i];
        end

        // Lagging write pointer makes this level conservative: it can only under-report.
        next_level        = wbin - next_bin;
        next_empty        = (next_gray == wsync2);
        next_almost_empty = (next_level <= PW'(AE_LEVEL));
    end

    always_ff @(posedge read_clk or negedge read_reset) begin
        if (!read_reset) begin
            bin            <= '0;
            gray           <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            level_q        <= '0;
            underflow_q    <= 1'b0;
        end else begin
            bin            <= next_bin;
            gray           <= next_gray;
            empty_q        <= next_empty;
            almost_empty_q <= next_almost_empty;
            level_q        <= next_level;
            if (bus.read_inc && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.read_addr    = bin[ADDR_SIZE-1:0];
    assign bus.read_ptr     = gray;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.read_level   = level_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_read_empty_ctrl.sv
// Directed bench for read_empty_ctrl: reset, single entry, drain, underflow,
// pointer wrap with a full level, and asynchronous reset in the middle of a drain.
module tb_read_empty_ctrl;
    logic read_clk;
    logic read_reset;
    int   compared;
    int   mismatched;

    read_empty_ctrl_if #(.ADDR_SIZE(4)) bus ();

    read_empty_ctrl #(.ADDR_SIZE(4), .AE_LEVEL(2)) dut (
        .read_clk   (read_clk),
        .read_reset (read_reset),
        .bus        (bus)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    function automatic logic [4:0] gray5(input int k);
        logic [4:0] b;
        b = 5'(k);
        return (b >> 1) ^ b;
    endfunction

    task automatic tick();
        @(posedge read_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".empty"},        32'(bus.empty),        32'd1);
        checkOutput({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'd1);
        checkOutput({tag, ".read_level"},   32'(bus.read_level),   32'd0);
        checkOutput({tag, ".read_addr"},    32'(bus.read_addr),    32'd0);
        checkOutput({tag, ".read_ptr"},     32'(bus.read_ptr),     32'd0);
        checkOutput({tag, ".underflow"},    32'(bus.underflow),    32'd0);
    endtask

    task automatic applyStimulus(input logic inc, input logic [4:0] wptr);
        bus.read_inc  = inc;
        bus.write_ptr = wptr;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset with five entries already visible on write_ptr.
        read_reset = 1'b0;
        applyStimulus(1'b0, 5'b00111);
        tick();
        tick();
        checkResetState("reset");
        read_reset = 1'b1;
        tick();
        tick();
        checkOutput("sync_edge2.level", 32'(bus.read_level), 32'd0);
        checkOutput("sync_edge2.empty", 32'(bus.empty), 32'd1);
        tick();
        checkOutput("sync_edge3.level", 32'(bus.read_level), 32'd5);
        checkOutput("sync_edge3.empty", 32'(bus.empty), 32'd0);
        checkOutput("sync_edge3.ae",    32'(bus.almost_empty), 32'd0);

        // Drain of five entries.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 5'b00111);
            tick();
            checkOutput($sformatf("drain%0d.addr", k),  32'(bus.read_addr),    32'(k));
            checkOutput($sformatf("drain%0d.level", k), 32'(bus.read_level),   32'(5 - k));
            checkOutput($sformatf("drain%0d.ae", k),    32'(bus.almost_empty), (5 - k <= 2) ? 32'd1 : 32'd0);
            checkOutput($sformatf("drain%0d.empty", k), 32'(bus.empty),        (k == 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("drain%0d.ptr", k),   32'(bus.read_ptr),     32'(gray5(k)));
        end
        checkOutput("drain.no_underflow", 32'(bus.underflow), 32'd0);

        // Read while empty: pointer holds, underflow sets and sticks.
        tick();
        checkOutput("underflow.addr", 32'(bus.read_addr), 32'd5);
        checkOutput("underflow.ptr",  32'(bus.read_ptr),  32'b00111);
        checkOutput("underflow.flag", 32'(bus.underflow), 32'd1);
        applyStimulus(1'b0, 5'b00111);
        tick();
        tick();
        checkOutput("underflow.sticky", 32'(bus.underflow), 32'd1);

        // Single entry from a fresh reset.
        read_reset = 1'b0;
        applyStimulus(1'b0, 5'b00000);
        tick();
        read_reset = 1'b1;
        checkResetState("reset2");
        applyStimulus(1'b0, 5'b00001);
        tick();
        tick();
        checkOutput("single_edge2.empty", 32'(bus.empty), 32'd1);
        tick();
        checkOutput("single_edge3.empty", 32'(bus.empty),        32'd0);
        checkOutput("single_edge3.level", 32'(bus.read_level),   32'd1);
        checkOutput("single_edge3.ae",    32'(bus.almost_empty), 32'd1);
        applyStimulus(1'b1, 5'b00001);
        tick();
        applyStimulus(1'b0, 5'b00001);
        checkOutput("single_read.empty", 32'(bus.empty),      32'd1);
        checkOutput("single_read.level", 32'(bus.read_level), 32'd0);
        checkOutput("single_read.addr",  32'(bus.read_addr),  32'd1);
        checkOutput("single_read.ptr",   32'(bus.read_ptr),   32'b00001);

        // Fill to a full FIFO from reset, then read across the pointer wrap.
        read_reset = 1'b0;
        applyStimulus(1'b0, 5'b00000);
        tick();
        read_reset = 1'b1;
        for (int w = 1; w <= 16; w++) begin
            applyStimulus(1'b0, gray5(w));
            tick();
        end
        tick();
        tick();
        checkOutput("full.level", 32'(bus.read_level),   32'd16);
        checkOutput("full.empty", 32'(bus.empty),        32'd0);
        checkOutput("full.ptr",   32'(bus.read_ptr),     32'd0);
        checkOutput("full.ae",    32'(bus.almost_empty), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, (k <= 4) ? gray5(16 + k) : gray5(20));
            tick();
            checkOutput($sformatf("wrap%0d.addr", k), 32'(bus.read_addr), 32'(k % 16));
            checkOutput($sformatf("wrap%0d.ptr", k),  32'(bus.read_ptr),  32'(gray5(k)));
            if (k == 10) begin
                checkOutput("wrap10.level", 32'(bus.read_level), 32'd10);
            end
        end
        applyStimulus(1'b0, gray5(20));
        checkOutput("wrap_end.empty", 32'(bus.empty),      32'd1);
        checkOutput("wrap_end.level", 32'(bus.read_level), 32'd0);
        checkOutput("wrap_end.uf",    32'(bus.underflow),  32'd0);

        // Build level 3, start draining, then reset between edges.
        for (int w = 21; w <= 23; w++) begin
            applyStimulus(1'b0, gray5(w));
            tick();
        end
        tick();
        tick();
        checkOutput("lvl3.level", 32'(bus.read_level),   32'd3);
        checkOutput("lvl3.ae",    32'(bus.almost_empty), 32'd0);
        applyStimulus(1'b1, gray5(23));
        tick();
        checkOutput("lvl3_pop.level", 32'(bus.read_level),   32'd2);
        checkOutput("lvl3_pop.ae",    32'(bus.almost_empty), 32'd1);
        checkOutput("lvl3_pop.addr",  32'(bus.read_addr),    32'd5);
        #3;
        read_reset = 1'b0;
        #1;
        checkResetState("async_reset");
        applyStimulus(1'b0, 5'b00000);
        tick();
        read_reset = 1'b1;
        tick();
        checkResetState("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/read_empty_ctrl.md
# read_empty_ctrl

Read-side pointer and empty-flag controller for the asynchronous FIFO, running entirely in the read clock domain. It is the counterpart to the write-side full logic. It synchronizes the Gray-coded write pointer into the read domain, advances the binary/Gray read pointer on accepted reads, and drives `empty`, `almost_empty`, a fill level and a sticky underflow flag. Its `read_ptr` output is the Gray pointer the write domain synchronizes for its full comparison.

## Interface
- `ADDR_SIZE`, default 4: FIFO address width; depth = 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- `AE_LEVEL`, default 2: `almost_empty` asserts when fill level ≤ AE_LEVEL.

- `read_clk`, input, 1: read-domain clock, all flops rising-edge.
- `read_reset`, input, 1: asynchronous, active-low reset.
- `read_inc`, input, 1: read request; honoured only when `empty`=0.
- `write_ptr`, input, ADDR_SIZE+1: Gray write pointer from the write domain; unsynchronized.
- `read_addr`, output, ADDR_SIZE: RAM read address = low ADDR_SIZE bits of the binary read pointer.
- `read_ptr`, output, ADDR_SIZE+1: registered Gray read pointer, sent to the write domain.
- `empty`, output, 1: registered FIFO-empty flag.
- `almost_empty`, output, 1: registered; level ≤ AE_LEVEL.
- `read_level`, output, ADDR_SIZE+1: registered entry count as seen by the read domain (0..2^ADDR_SIZE).
- `underflow`, output, 1: sticky; read attempted while empty.

## Operation
- Synchronizer: two flops, `wsync1` ← `write_ptr`, then `wsync2` ← `wsync1`. Both flops reset to 0.
- `next_bin` = `bin` + (`read_inc` & ~`empty`), computed modulo 2^(ADDR_SIZE+1).
- `next_gray` = (`next_bin` >> 1) ^ `next_bin`.
- `next_empty` = (`next_gray` == `wsync2`), compared on all ADDR_SIZE+1 bits.
- `wbin` = Gray-to-binary of `wsync2`: MSB passes through; each lower bit is the XOR of all higher Gray bits with its own bit.
- `next_level` = `wbin` − `next_bin`, computed modulo 2^(ADDR_SIZE+1).
- `next_level`=0 exactly when `next_empty`=1.
- Registered every edge: `bin`, `gray`, `empty`, `read_level` ← `next_level`, `almost_empty` ← (`next_level` ≤ AE_LEVEL).
- `underflow` sets on any edge where `read_inc`=1 and `empty`=1. It clears only on reset.
- A read while empty does not move `bin` or `gray`.
- Wrap-around: `bin` rolls from 2^(ADDR_SIZE+1)−1 to 0. `read_addr` wraps every 2^ADDR_SIZE reads.
- The extra MSB distinguishes a full FIFO from an empty one. Level 2^ADDR_SIZE is legal.
- The level is conservative: the synchronized write pointer lags, so `read_level` may under-report and never over-reports.
- Reset values: `read_addr`=0, `read_ptr`=0, `empty`=1, `almost_empty`=1, `read_level`=0, `underflow`=0.
- Reset mid-operation discards all pointer state immediately (asynchronous). The write side must be reset together with this block.

## Timing
- Accepted read: `read_addr`, `read_ptr`, `empty`, `read_level` and `almost_empty` update on the same edge that samples `read_inc`=1. Latency is 1 edge.
- Write-pointer change: reflected in `empty` and `read_level` on the 3rd `read_clk` edge after `write_ptr` changes (2 synchronizer stages + 1 output register).
- Simultaneous read and write arrival: the level nets both effects. For example, level 1, a pop, and a newly synchronized write give level 1 and `empty` stays 0.
- `read_ptr` changes at most one bit per `read_clk` edge.
- `write_ptr` is required to change at most one bit per write-clock edge.
- There is no combinational path from any input to any output.

## Test plan
- Reset: hold `read_reset`=0 with `write_ptr`=5'b00111 → `empty`=1, `almost_empty`=1, `read_level`=0, `read_addr`=0, `read_ptr`=0, `underflow`=0. After release, `read_level` becomes 5 on the 3rd edge.
- Single entry: from reset, set `write_ptr`=5'b00001 with `read_inc`=0 → `empty` falls on the 3rd edge, `read_level`=1, `almost_empty`=1. One read → `empty`=1, `read_level`=0, `read_addr`=1, `read_ptr`=5'b00001.
- Drain of 5 (`write_ptr`=gray(5)=5'b00111), then `read_inc`=1 for 5 edges:
  - `read_addr` steps 1..5 and `read_level` steps 4,3,2,1,0.
  - `almost_empty` rises when level reaches 2.
  - `empty`=1 after the 5th read, with `read_ptr`=5'b00111.
- Underflow: `read_inc`=1 while `empty`=1 → `read_addr` and `read_ptr` unchanged, `underflow`=1 next edge. `underflow` stays 1 after `read_inc` drops and until reset.
- Wrap: advance `write_ptr` through the Gray sequence to gray(20) while reading continuously.
  - `read_ptr` passes gray(15)=5'b01000 then gray(16)=5'b11000.
  - `read_addr` wraps 15→0.
  - Full level: with `write_ptr`=5'b11000 and `read_ptr`=0, `read_level`=16, `empty`=0.
- Reset mid-drain: assert `read_reset` low between edges at level 3 → all outputs return to reset values immediately, without waiting for a clock edge.
